// File: rtl/alu_divmod_decomp_pkg.sv
// Shared types and default widths for the ALU divide/modulo decomposition block.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } state_t;

    localparam int NW_DEF = 8;
    localparam int DW_DEF = 4;
    localparam int CNT_W  = $clog2(NW_DEF);

    // Iteration counter must still be one bit wide for degenerate widths.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_divmod_decomp_if.sv
// Request/response bundle for alu_divmod_decomp: valid/ready on both the operand and result sides.
interface alu_divmod_decomp_if
    import alu_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] num;
    logic [DW-1:0] div;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] quot;
    logic [DW:0]   rem;
    logic          dz;
    logic          fits;

    modport master (
        output in_valid, num, div, out_ready,
        input  in_ready, out_valid, quot, rem, dz, fits
    );

    modport slave (
        input  in_valid, num, div, out_ready,
        output in_ready, out_valid, quot, rem, dz, fits
    );

endinterface

// File: rtl/alu_divmod_decomp_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor when it fits.
module alu_divmod_step
    import alu_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW:0]   prem,
    input  logic          nbit,
    input  logic [DW-1:0] dvs,
    output logic [DW:0]   prem_nxt,
    output logic          qbit
);

    localparam int RW = DW + 1;

    logic [DW+1:0] sh;
    logic [DW+1:0] dvs_ext;

    assign sh       = {prem, nbit};
    assign dvs_ext  = {2'b00, dvs};
    assign qbit     = (sh >= dvs_ext);
    // The partial remainder stays below the divisor, so the top bit of the difference is always zero.
    assign prem_nxt = RW'(sh - (qbit ? dvs_ext : '0));

endmodule

// File: rtl/alu_divmod_decomp.sv
// Signed-by-unsigned sequential divider recovering B (quot) and A (rem) from OUT = A + B*C.
// Optional ALU_DIVMOD_FIT_CHECK_EN: registers whether quot/rem both fit in DW-bit signed; otherwise fits=0.
module alu_divmod_decomp
    import alu_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    alu_divmod_decomp_if.slave  bus
);

    localparam int CW = cnt_width(NW);

    state_t        state, state_nxt;
    logic [NW-1:0] mag;
    logic [DW-1:0] dvs;
    logic          neg;
    logic [DW:0]   prem;
    logic [CW-1:0] cnt;
    logic [NW-1:0] quot_r;
    logic [DW:0]   rem_r;
    logic          dz_r;

    logic [DW:0]   prem_nxt;
    logic          qbit;
    logic [NW-1:0] num_abs;
    logic [NW-1:0] quot_s;
    logic [DW:0]   rem_s;

    alu_divmod_step #(.DW(DW)) u_step (
        .prem     (prem),
        .nbit     (mag[NW-1]),
        .dvs      (dvs),
        .prem_nxt (prem_nxt),
        .qbit     (qbit)
    );

    // |-2^(NW-1)| wraps to the same bit pattern, which reads correctly as an unsigned magnitude.
    assign num_abs = bus.num[NW-1] ? -bus.num : bus.num;
    assign quot_s  = neg ? -mag  : mag;
    assign rem_s   = neg ? -prem : prem;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = (bus.div == '0) ? DONE : CALC;
            end
            CALC: if (cnt == '0) state_nxt = SIGN;
            SIGN: state_nxt = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The dividend register doubles as the quotient: bits leave at the top, quotient bits enter at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag    <= '0;
            dvs    <= '0;
            neg    <= 1'b0;
            prem   <= '0;
            cnt    <= '0;
            quot_r <= '0;
            rem_r  <= '0;
            dz_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    mag    <= num_abs;
                    dvs    <= bus.div;
                    neg    <= bus.num[NW-1];
                    prem   <= '0;
                    cnt    <= CW'(NW - 1);
                    quot_r <= '0;
                    rem_r  <= '0;
                    dz_r   <= (bus.div == '0);
                end
                CALC: begin
                    prem <= prem_nxt;
                    mag  <= {mag[NW-2:0], qbit};
                    cnt  <= cnt - CW'(1);
                end
                SIGN: begin
                    quot_r <= quot_s;
                    rem_r  <= rem_s;
                end
                default: ;
            endcase
        end
    end

    assign bus.quot = quot_r;
    assign bus.rem  = rem_r;
    assign bus.dz   = dz_r;

`ifdef ALU_DIVMOD_FIT_CHECK_EN
    localparam int FMAX = (1 << (DW - 1)) - 1;
    localparam int FMIN = -(1 << (DW - 1));

    logic signed [NW-1:0] qs;
    logic signed [DW:0]   rs;
    logic                 fits_s;
    logic                 fits_r;

    assign qs     = quot_s;
    assign rs     = rem_s;
    assign fits_s = (int'(qs) >= FMIN) && (int'(qs) <= FMAX) &&
                    (int'(rs) >= FMIN) && (int'(rs) <= FMAX);

    always_ff @(posedge clk) begin
        if (rst)                               fits_r <= 1'b0;
        else if (state == IDLE && bus.in_valid) fits_r <= 1'b0;
        else if (state == SIGN)                 fits_r <= fits_s;
    end

    assign bus.fits = fits_r;
`else
    assign bus.fits = 1'b0;
`endif

endmodule

// File: doc/alu_divmod_decomp.md
# alu_divmod_decomp

Sequential signed-by-unsigned divider that inverts the ALU relation OUT = A + B*C. It takes a signed ALU result and an unsigned C and recovers B as the truncated quotient and A as the remainder, so that NUM = QUOT*DIV + REM holds exactly. It sits downstream of the ALU as a checker and reverse-mapping unit, and uses valid/ready handshakes on both sides.

## Interface
Parameters:
- NW, default 8: dividend width, signed; matches the ALU OUT width.
- DW, default 4: divisor width, unsigned; matches the ALU C width.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: NUM/DIV are valid.
- in_ready, output, 1: block can accept an operation.
- num, input, NW: signed dividend (ALU OUT).
- div, input, DW: unsigned divisor (ALU C).
- out_valid, output, 1: results are valid.
- out_ready, input, 1: consumer accepts the results.
- quot, output, NW: signed quotient (recovered B).
- rem, output, DW+1: signed remainder (recovered A).
- dz, output, 1: divide-by-zero flag.
- fits, output, 1: both quot and rem are representable as DW-bit signed values (a legal A/B pair).

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch |num| as an NW-bit unsigned magnitude (|-128| = 128), latch div and the sign of num, clear the partial remainder, load the iteration counter with NW-1.
  - If div==0: go to DONE with quot=0, rem=0, dz=1, fits=0. Otherwise go to CALC.
- CALC:
  - One restoring step per cycle, MSB first: shift the next dividend bit into the partial remainder (DW+1 bits unsigned), subtract div if the partial remainder is >= div, and shift the quotient bit in.
  - Counter decrements each step; after NW steps go to SIGN.
- SIGN:
  - Division truncates toward zero.
  - If num<0: negate both quotient and remainder, so the remainder takes the sign of num and |rem| < div.
  - The quotient never overflows: the magnitude is at most 128, and 128 only occurs with a negative sign.
  - Compute fits as -2^(DW-1) <= quot, rem <= 2^(DW-1)-1.
  - Go to DONE.
- DONE:
  - out_valid=1; quot, rem, dz and fits are held stable.
  - On out_ready: go to IDLE.
- in_ready is 0 in every state except IDLE. There is no overlap of operations.

## Timing
- Reset values: in_ready=1, out_valid=0, quot=0, rem=0, dz=0, fits=0; state=IDLE.
- Latency: with acceptance at edge N, out_valid rises after edge N+NW+2 (N+10 at the default widths).
  - Divide-by-zero: out_valid rises after edge N+1.
- Throughput: one operation per NW+3 cycles when out_ready is held high.
- Back-pressure: in DONE with out_ready=0, every output holds indefinitely.
- Simultaneous out_ready and in_valid in DONE: the result is consumed; the new input is not accepted until the following cycle in IDLE.
- Reset mid-operation (any state): the next cycle shows the reset values and the in-flight operation is discarded without a result.
- Inputs num and div are sampled only on acceptance; changes afterwards are ignored.

## Configuration
- ALU_DIVMOD_FIT_CHECK_EN:
  - Defined: fits is computed in SIGN as specified and registered with the results.
  - Undefined: the fits logic is removed and the port is tied to 0.

## Structure
- Package alu_pkg holds:
  - The state enum (IDLE/CALC/SIGN/DONE).
  - Default width constants NW_DEF=8 and DW_DEF=4.
  - An iteration-count width constant, $clog2(NW).
- One sub-module: alu_divmod_step, a combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once and iterated by the FSM.

## Test plan
- num=-55 (8'hC9), div=10 -> quot=-5, rem=-5, fits=1, dz=0; out_valid 10 cycles after acceptance.
- num=112, div=15 -> quot=7, rem=7, fits=1. Also num=33, div=10 -> quot=3, rem=3, fits=1.
- num=-128, div=15 -> quot=-8, rem=-8, fits=1. Also num=-128, div=1 -> quot=-128, rem=0, fits=0.
- num=127, div=0 -> dz=1, quot=0, rem=0, fits=0; out_valid 1 cycle after acceptance.
- Back-pressure and handshake: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; assert in_valid together with out_ready -> the new input is accepted one cycle later.
- Reset mid-CALC at step 4 -> the next cycle has out_valid=0, in_ready=1, quot=0, rem=0; no stale result appears afterwards.
